// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 receiver: FSM states, prefix codes and the FIFO entry.
// Entry layout depends on PS2_BREAK_DECODE_EN (adds ext/brk bits when defined).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PS2_PREFIX_BREAK = 8'hF0;
  localparam logic [7:0] PS2_PREFIX_EXT   = 8'hE0;

`ifdef PS2_BREAK_DECODE_EN
  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_entry_t;
`else
  typedef struct packed {
    logic [7:0] code;
  } ps2_entry_t;
`endif

  // Odd parity: data bits plus parity bit must hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return (^d) ^ p;
  endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Synchronises raw PS/2 clock/data, glitch-filters the clock, emits a falling-edge strobe.
// Latency: SYNC_STAGES + FILTER_LEN cycles from pin to strobe; no backpressure.
module ps2_sync_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_ps2_clk,
  input  logic i_ps2_dat,
  output logic o_ps2_dat,
  output logic o_fall_stb
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic [SYNC_STAGES-1:0] r_clk_sync;
  logic [SYNC_STAGES-1:0] r_dat_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_filt;
  logic                   r_filt_d;
  logic                   w_clk_s;

  assign w_clk_s = r_clk_sync[SYNC_STAGES-1];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_clk_sync <= '1;
      r_dat_sync <= '1;
      r_cnt      <= '0;
      r_filt     <= 1'b1;
      r_filt_d   <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
      r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
      r_filt_d   <= r_filt;
      // The filtered level moves only after FILTER_LEN consecutive disagreeing samples.
      if (w_clk_s == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_filt <= w_clk_s;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_ps2_dat  = r_dat_sync[SYNC_STAGES-1];
  assign o_fall_stb = r_filt_d & ~r_filt;

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver feeding a first-word-fall-through scan-code FIFO (PS2_BREAK_DECODE_EN folds F0/E0 prefixes into flags).
// Latency: byte pushed the cycle after the stop-bit strobe; visible one cycle later. Full FIFO drops bytes (sticky overflow).
module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int SYNC_STAGES    = 2,
  parameter int FILTER_LEN     = 4,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clock_fpga,
  input  logic                        reset,
  input  logic                        clock_key,
  input  logic                        data_key,
  input  logic                        rd_en,
  output logic [7:0]                  data_out,
  output logic                        data_valid,
  output logic                        break_flag,
  output logic                        ext_flag,
  output logic                        parity_err,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fill,
  output logic                        led
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic            w_dat;
  logic            w_stb;
  ps2_state_e      r_state, w_state_nxt;
  logic [7:0]      r_shift, w_shift_nxt;
  logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
  logic            r_par, w_par_nxt;
  logic [TW-1:0]   r_to_cnt;
  logic            w_timeout;
  logic            w_accept, w_par_err, w_frm_err;
  logic            r_acc_vld;
  logic [7:0]      r_acc_dat;
  logic            r_par_err, r_frm_err;
  logic            w_push;
  ps2_entry_t      w_push_entry;

  ps2_sync_filter #(
    .SYNC_STAGES (SYNC_STAGES),
    .FILTER_LEN  (FILTER_LEN)
  ) u_sync_filter (
    .i_clk      (clock_fpga),
    .i_rst_n    (reset),
    .i_ps2_clk  (clock_key),
    .i_ps2_dat  (data_key),
    .o_ps2_dat  (w_dat),
    .o_fall_stb (w_stb)
  );

  assign w_timeout = (r_state != IDLE) && !w_stb &&
                     (r_to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_par_nxt     = r_par;
    w_accept      = 1'b0;
    w_par_err     = 1'b0;
    w_frm_err     = 1'b0;
    if (w_timeout) begin
      w_state_nxt   = IDLE;
      w_frm_err     = 1'b1;
      w_shift_nxt   = '0;
      w_bit_cnt_nxt = '0;
    end else if (w_stb) begin
      case (r_state)
        IDLE: begin
          if (!w_dat) begin
            w_state_nxt   = DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_frm_err = 1'b1;
          end
        end
        DATA: begin
          w_shift_nxt   = {w_dat, r_shift[7:1]};
          w_bit_cnt_nxt = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) w_state_nxt = PARITY;
        end
        PARITY: begin
          w_par_nxt   = w_dat;
          w_state_nxt = STOP;
        end
        STOP: begin
          w_state_nxt = IDLE;
          if (!w_dat)                            w_frm_err = 1'b1;
          else if (odd_parity_ok(r_shift, r_par)) w_accept  = 1'b1;
          else                                   w_par_err = 1'b1;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_par     <= 1'b0;
      r_to_cnt  <= '0;
      r_acc_vld <= 1'b0;
      r_acc_dat <= '0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_par     <= w_par_nxt;
      r_to_cnt  <= (r_state == IDLE || w_stb) ? '0 : r_to_cnt + TW'(1);
      r_acc_vld <= w_accept;
      r_acc_dat <= r_shift;
      r_par_err <= w_par_err;
      r_frm_err <= w_frm_err;
    end
  end

`ifdef PS2_BREAK_DECODE_EN
  logic r_pend_brk, r_pend_ext;

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      r_pend_brk <= 1'b0;
      r_pend_ext <= 1'b0;
    end else if (r_par_err || r_frm_err) begin
      r_pend_brk <= 1'b0;
      r_pend_ext <= 1'b0;
    end else if (r_acc_vld) begin
      if (r_acc_dat == PS2_PREFIX_BREAK)    r_pend_brk <= 1'b1;
      else if (r_acc_dat == PS2_PREFIX_EXT) r_pend_ext <= 1'b1;
      else begin
        r_pend_brk <= 1'b0;
        r_pend_ext <= 1'b0;
      end
    end
  end

  assign w_push = r_acc_vld && (r_acc_dat != PS2_PREFIX_BREAK) &&
                  (r_acc_dat != PS2_PREFIX_EXT);
  assign w_push_entry = '{ext: r_pend_ext, brk: r_pend_brk, code: r_acc_dat};
`else
  assign w_push       = r_acc_vld;
  assign w_push_entry = '{code: r_acc_dat};
`endif

  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_ovf;
  ps2_entry_t    r_mem [FIFO_DEPTH];
  ps2_entry_t    w_head;
  logic          w_empty, w_full, w_pop, w_wr;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == (AW+1)'(FIFO_DEPTH));
  assign w_pop   = rd_en && !w_empty;
  // A pop in the same cycle frees the head slot, so a full FIFO can still accept.
  assign w_wr    = w_push && (!w_full || w_pop);

  always_ff @(posedge clock_fpga) begin
    if (w_wr) r_mem[r_wr_ptr] <= w_push_entry;
  end

  always_ff @(posedge clock_fpga or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_push && !w_wr) r_ovf <= 1'b1;
    end
  end

  assign w_head     = r_mem[r_rd_ptr];
  assign data_valid = !w_empty;
  assign data_out   = data_valid ? w_head.code : 8'h00;
`ifdef PS2_BREAK_DECODE_EN
  assign break_flag = data_valid & w_head.brk;
  assign ext_flag   = data_valid & w_head.ext;
`else
  assign break_flag = 1'b0;
  assign ext_flag   = 1'b0;
`endif
  assign parity_err = r_par_err;
  assign frame_err  = r_frm_err;
  assign overflow   = r_ovf;
  assign fill       = r_count;
  assign led        = data_valid;

endmodule

// File: doc/ps2_rx_fifo.md
PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

Interface
REQ-001 Parameter SYNC_STAGES, default 2: synchroniser flops on clock_key and data_key; minimum 2.
REQ-002 Parameter FILTER_LEN, default 4: consecutive equal synchronised samples needed to change filtered clock_key.
REQ-003 Parameter FIFO_DEPTH, default 8: scan-code FIFO entries; power of two, 2..64.
REQ-004 Parameter TIMEOUT_CYCLES, default 50000: idle clock_fpga cycles allowed between PS/2 clock falling edges inside a frame.
REQ-005 Port list:
- clock_fpga  in  1  system clock; the block's only clock.
- reset  in  1  asynchronous, active-low reset.
- clock_key  in  1  raw PS/2 clock, asynchronous.
- data_key  in  1  raw PS/2 data, asynchronous.
- rd_en  in  1  pop the head entry; ignored when data_valid=0.
- data_out  out  8  head scan code, first-word fall-through.
- data_valid  out  1  FIFO non-empty.
- break_flag  out  1  head entry was preceded by F0.
- ext_flag  out  1  head entry was preceded by E0.
- parity_err  out  1  one-cycle pulse on a bad parity bit.
- frame_err  out  1  one-cycle pulse on bad start bit, bad stop bit or timeout.
- overflow  out  1  sticky; a byte was dropped on a full FIFO.
- fill  out  $clog2(FIFO_DEPTH)+1  current entry count.
- led  out  1  equals data_valid.

Function
REQ-006 Both raw inputs SHALL pass SYNC_STAGES flops; clock_key then SHALL pass the FILTER_LEN glitch filter; a falling edge of the filtered clock SHALL produce a one-cycle sample strobe.
REQ-007 The receive FSM SHALL have states IDLE, DATA, PARITY and STOP.
- IDLE: sample data 0 -> DATA; sample data 1 -> frame_err, stay in IDLE.
- DATA: shift in 8 bits, LSB first -> PARITY.
- PARITY: capture the parity bit -> STOP.
- STOP: sample data 1 with good parity -> accept; data 1 with bad parity -> parity_err; data 0 -> frame_err only. Every STOP outcome -> IDLE.
REQ-008 Parity SHALL be odd: the XOR of the 8 data bits and the parity bit equals 1.
REQ-009 In any state other than IDLE, TIMEOUT_CYCLES cycles without a strobe SHALL pulse frame_err and return the FSM to IDLE, discarding the partial byte.
REQ-010 An accepted byte SHALL be pushed in cycle N+1, where N is the stop-bit strobe cycle; data_valid and fill SHALL update in cycle N+2.
REQ-011 Push while full with no pop SHALL drop the byte and set overflow; overflow SHALL clear only on reset.
REQ-012 Push and pop in the same cycle SHALL both succeed at any fill, including full, leaving fill unchanged.
REQ-013 Pop while empty SHALL be ignored; the pointers SHALL wrap modulo FIFO_DEPTH.
REQ-014 When data_valid=0, data_out, break_flag and ext_flag SHALL be 0.

Reset
REQ-015 reset low SHALL asynchronously clear:
- FSM to IDLE; shift register, timeout counter and pointers to 0.
- Synchroniser and filter state to 1, the PS/2 idle level.
- Every output to 0.
REQ-016 Reset asserted mid-frame or with a non-empty FIFO SHALL discard all data; the first frame after deassertion SHALL be received normally.

Configuration
REQ-017 Macro PS2_BREAK_DECODE_EN defined:
- An accepted byte F0 SHALL set a pending-break flag and an accepted E0 a pending-extended flag; neither byte is pushed.
- The next non-prefix byte SHALL be pushed as a 10-bit entry {ext, brk, code}, and both pending flags then clear.
- A parity or frame error SHALL also clear both pending flags.
REQ-018 Macro PS2_BREAK_DECODE_EN undefined: every accepted byte, including F0 and E0, SHALL be pushed as an 8-bit entry; break_flag and ext_flag SHALL be tied to 0.

Structure
REQ-019 Package ps2_pkg SHALL hold the FSM state enum, PS2_PREFIX_BREAK = 8'hF0, PS2_PREFIX_EXT = 8'hE0 and the FIFO entry struct.
REQ-020 Sub-module ps2_sync_filter SHALL implement the synchroniser, glitch filter and falling-edge strobe, instantiated once per design.

Verification
REQ-021 Frame 0x1C with parity 0 and stop 1 -> data_valid=1, data_out=0x1C, no error pulses; rd_en -> data_valid=0.
REQ-022 Frame 0x1C with parity 1 -> one parity_err pulse; fill stays 0.
REQ-023 (macro defined) bytes E0, F0, 0x75 -> one entry: data_out=0x75, break_flag=1, ext_flag=1. (macro undefined) same bytes -> three entries: E0, F0, 75.
REQ-024 FIFO_DEPTH=8: send 9 bytes with no reads -> fill=8, overflow=1; the 9th byte is absent. Then rd_en held while a 10th byte arrives -> fill=8 and the 10th byte is stored.
REQ-025 Stop clock_key after 4 data bits for TIMEOUT_CYCLES+1 cycles -> one frame_err pulse. A following valid frame 0x29 -> data_out=0x29.
REQ-026 Assert reset mid-frame with fill=3 -> all outputs 0 immediately; a clean frame 0x5A after release -> fill=1, data_out=0x5A.
